uart_frame_tx: RTL

UART_FRAME_TX -- requirements
Module: uart_frame_tx

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_baud_gen.sv | 45 ++++
 rtl/uart_frame_tx.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame transmitter.
// Holds the parity selector, the transmit FSM state encoding, the CR/LF
// characters appended when UART_TX_CRLF_EN is defined, and a parity helper.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    // XOR of the low data_bits bits of ch; inverted for odd parity so the
    // total count of ones including the parity bit comes out odd.
    function automatic logic parity_bit(input logic [7:0] ch, input int data_bits,
                                        input parity_t par);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < data_bits) begin
                p = p ^ ch[i];
            end
        end
        return (par == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: pulses tick_o for one cycle every DIV cycles while en is
// high. Dropping en clears the count, so the first tick after en rises comes
// exactly DIV cycles later.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_baud_gen: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          wrap;

    assign wrap   = (cnt_q == CW'(DIV - 1));
    assign tick_o = en && wrap;

    // Next count: hold at zero while disabled, wrap to zero at the end of a period.
    always_comb begin
        cnt_d = cnt_q;
        if (!en || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Period counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Message-level UART transmitter: on a single-cycle update request it latches
// CHAR_NR characters and sends them back-to-back, char 0 first, each framed as
// start bit, LSB-first data, optional parity and one or two stop bits.
// Optional feature macro: UART_TX_CRLF_EN appends 0x0D, 0x0A to every message.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int      CHAR_NR   = 8,
    parameter int      CLK_HZ    = 100_000_000,
    parameter int      BAUD      = 115_200,
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHAR_NR*8-1:0] char_array_i,
    input  logic                 char_array_update_i,
    input  logic                 clr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 txd_o
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;

`ifdef UART_TX_CRLF_EN
    localparam int TOTAL_CHARS = CHAR_NR + 2;
`else
    localparam int TOTAL_CHARS = CHAR_NR;
`endif

    localparam int BUF_W = TOTAL_CHARS * 8;
    localparam int CC_W  = $clog2(TOTAL_CHARS + 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_frame_tx: CLK_HZ/BAUD gives a bit period below 2 cycles");
    end
    if (DATA_BITS != 7 && DATA_BITS != 8) begin : g_data_bits_check
        $error("uart_frame_tx: DATA_BITS must be 7 or 8");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_bits_check
        $error("uart_frame_tx: STOP_BITS must be 1 or 2");
    end

    state_t           state_q;
    logic [BUF_W-1:0] data_q;
    logic [CC_W-1:0]  char_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic             stop_cnt_q;
    logic             txd_q;
    logic             busy_q;
    logic             done_q;
    logic             baud_tick;
    logic [7:0]       cur_char;
    logic [BUF_W-1:0] load_data;

    // The character on the wire is always the low byte; the buffer shifts down
    // by one byte as each character completes.
    assign cur_char = data_q[7:0];

`ifdef UART_TX_CRLF_EN
    assign load_data = {CHAR_LF, CHAR_CR, char_array_i};
`else
    assign load_data = char_array_i;
`endif

    uart_baud_gen #(
        .DIV(DIV)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q != IDLE),
        .tick_o(baud_tick)
    );

    // Transmit FSM with registered line, busy and done outputs; reset beats clear beats update.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            state_q    <= IDLE;
            char_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            if (rst) begin
                data_q <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (char_array_update_i) begin
                        data_q     <= load_data;
                        char_cnt_q <= '0;
                        state_q    <= START;
                        txd_q      <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        state_q   <= DATA;
                        bit_cnt_q <= '0;
                        txd_q     <= cur_char[0];
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            if (PARITY != PAR_NONE) begin
                                state_q <= PAR;
                                txd_q   <= parity_bit(cur_char, DATA_BITS, PARITY);
                            end else begin
                                state_q    <= STOP;
                                stop_cnt_q <= 1'b0;
                                txd_q      <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            txd_q     <= cur_char[bit_cnt_q + 3'd1];
                        end
                    end
                end
                PAR: begin
                    if (baud_tick) begin
                        state_q    <= STOP;
                        stop_cnt_q <= 1'b0;
                        txd_q      <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                            if (char_cnt_q == CC_W'(TOTAL_CHARS - 1)) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                txd_q   <= 1'b1;
                            end else begin
                                state_q    <= START;
                                char_cnt_q <= char_cnt_q + 1'b1;
                                data_q     <= data_q >> 8;
                                txd_q      <= 1'b0;
                            end
                        end else begin
                            stop_cnt_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign txd_o  = txd_q;

endmodule
